inst_mem: RTL and testbench

Instruction store that answers the processor's fetch port: it holds DEPTH instruction bytes and returns the byte at a requested 3-bit address one cycle after a fetch request. Contents are written through a byte-serial program-load port (switch bank, debounced strobe) with an auto-incrementing write pointer. Fetches are served only after a complete program image has been loaded. It sits between the board's load inputs and the processor's `address`/`instruction` pins.

---
 rtl/inst_mem_if.sv | 28 ++
 rtl/inst_mem.sv | 92 +++++++++
 tb/tb_inst_mem.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/inst_mem_if.sv
// Fetch and program-load signal bundle between the processor/board and inst_mem.
interface inst_mem_if #(
  parameter int AW    = 3,
  parameter int WIDTH = 8
);
  logic             fetch_req;
  logic [AW-1:0]    fetch_addr;
  logic [WIDTH-1:0] instruction;
  logic             fetch_valid;
  logic             fetch_err;
  logic             load_stb;
  logic [WIDTH-1:0] load_data;
  logic             load_restart;
  logic             ready;
  logic [AW-1:0]    wr_ptr;

  // Requester side: processor fetch port plus board load inputs.
  modport master (
    output fetch_req, fetch_addr, load_stb, load_data, load_restart,
    input  instruction, fetch_valid, fetch_err, ready, wr_ptr
  );

  // Memory side.
  modport slave (
    input  fetch_req, fetch_addr, load_stb, load_data, load_restart,
    output instruction, fetch_valid, fetch_err, ready, wr_ptr
  );
endinterface

// File: rtl/inst_mem.sv
// Instruction store: byte-serial program load with auto-incrementing pointer,
// registered single-cycle fetch served only once a full image is loaded.
module inst_mem #(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int WIDTH = 8
) (
  input logic       clk,
  input logic       rst,
  inst_mem_if.slave bus
);

  localparam logic [0:0] S_LOAD = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic             wr_en;
  logic             serve;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] instr_q;
  logic             fetch_valid_q;
  logic             fetch_err_q;

  // Load control: restart has priority over a coincident strobe; the write at
  // the last entry wraps the pointer and makes the image ready.
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    wr_en    = 1'b0;
    if (bus.load_restart) begin
      wr_ptr_d = '0;
      state_d  = S_LOAD;
    end else if (state_q == S_LOAD && bus.load_stb) begin
      wr_en    = 1'b1;
      wr_ptr_d = wr_ptr_q + AW'(1);
      if (wr_ptr_q == AW'(DEPTH - 1)) begin
        state_d = S_RUN;
      end
    end
  end

  // Readiness is taken from the current state, so a request alongside the
  // final write is rejected and one alongside a restart is still served.
  always_comb begin
    serve = bus.fetch_req && (state_q == S_RUN);
  end

  // State and write pointer registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_LOAD;
      wr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // Storage array, cleared by reset, written only by an accepted load strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[wr_ptr_q] <= bus.load_data;
    end
  end

  // Fetch response: instruction updates only on a served request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr_q       <= '0;
      fetch_valid_q <= 1'b0;
      fetch_err_q   <= 1'b0;
    end else begin
      fetch_valid_q <= serve;
      fetch_err_q   <= bus.fetch_req && !serve;
      if (serve) begin
        instr_q <= mem_q[bus.fetch_addr];
      end
    end
  end

  assign bus.instruction = instr_q;
  assign bus.fetch_valid = fetch_valid_q;
  assign bus.fetch_err   = fetch_err_q;
  assign bus.ready       = (state_q == S_RUN);
  assign bus.wr_ptr      = wr_ptr_q;

endmodule

// File: tb/tb_inst_mem.sv
// Directed bench for inst_mem with a fetch-response scoreboard.
module tb_inst_mem;

  typedef struct packed {
    logic       err;
    logic [7:0] data;
  } exp_t;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;
  exp_t sb[$];

  logic [7:0] m_mem [8];
  logic [2:0] m_ptr;
  logic       m_run;
  logic [7:0] m_instr;

  inst_mem_if #(.AW(3), .WIDTH(8)) bus ();

  inst_mem #(.DEPTH(8), .AW(3), .WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, ".ready"}, 32'(bus.ready), 32'(m_run));
    check({tag, ".wr_ptr"}, 32'(bus.wr_ptr), 32'(m_ptr));
  endtask

  // One clock cycle with whatever inputs are currently driven.
  task automatic cyc(input string tag);
    logic had_req;
    exp_t e;
    had_req = bus.fetch_req;
    if (bus.fetch_req) begin
      if (m_run) begin
        m_instr = m_mem[bus.fetch_addr];
        sb.push_back('{err: 1'b0, data: m_instr});
      end else begin
        sb.push_back('{err: 1'b1, data: m_instr});
      end
    end
    if (bus.load_restart) begin
      m_ptr = '0;
      m_run = 1'b0;
    end else if (!m_run && bus.load_stb) begin
      m_mem[m_ptr] = bus.load_data;
      if (m_ptr == 3'd7) m_run = 1'b1;
      m_ptr = m_ptr + 3'd1;
    end
    @(posedge clk);
    #1;
    if (had_req) begin
      if (sb.size() == 0) begin
        check({tag, ".sb_empty"}, 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check({tag, ".fetch_err"}, 32'(bus.fetch_err), 32'(e.err));
        check({tag, ".fetch_valid"}, 32'(bus.fetch_valid), 32'(!e.err));
        check({tag, ".instruction"}, 32'(bus.instruction), 32'(e.data));
      end
    end else begin
      check({tag, ".idle_valid"}, 32'(bus.fetch_valid), 32'd0);
      check({tag, ".idle_err"}, 32'(bus.fetch_err), 32'd0);
      check({tag, ".held_instr"}, 32'(bus.instruction), 32'(m_instr));
    end
    check_state(tag);
    bus.fetch_req    = 1'b0;
    bus.load_stb     = 1'b0;
    bus.load_restart = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) m_mem[i] = '0;
    m_ptr   = '0;
    m_run   = 1'b0;
    m_instr = '0;
    sb.delete();
    #2;
    check({tag, ".instruction"}, 32'(bus.instruction), 32'h0);
    check({tag, ".fetch_valid"}, 32'(bus.fetch_valid), 32'd0);
    check({tag, ".fetch_err"}, 32'(bus.fetch_err), 32'd0);
    check_state(tag);
    for (int i = 0; i < 8; i++) check({tag, ".mem"}, 32'(dut.mem_q[i]), 32'h0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic load(input logic [7:0] data, input string tag);
    bus.load_stb  = 1'b1;
    bus.load_data = data;
    cyc(tag);
  endtask

  task automatic fetch(input logic [2:0] addr, input string tag);
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = addr;
    cyc(tag);
  endtask

  initial begin
    vectors          = 0;
    miscompares      = 0;
    bus.fetch_req    = 1'b0;
    bus.fetch_addr   = '0;
    bus.load_stb     = 1'b0;
    bus.load_data    = '0;
    bus.load_restart = 1'b0;
    do_reset("por");

    cyc("idle0");
    cyc("idle1");
    fetch(3'd3, "fetch_in_load");

    for (int i = 0; i < 8; i++) load(8'h10 + 8'(i), "load1");
    check("ready_after_load1", 32'(bus.ready), 32'd1);

    for (int i = 0; i < 8; i++) fetch(3'(i), "b2b_fetch");

    load(8'hFF, "stb_in_run");
    fetch(3'd0, "addr0_after_ignored_stb");

    bus.load_restart = 1'b1;
    cyc("restart");
    load(8'hAA, "reload_aa");
    for (int i = 1; i < 8; i++) load(8'h10 + 8'(i), "reload_rest");
    fetch(3'd0, "fetch_aa");

    bus.load_restart = 1'b1;
    bus.load_stb     = 1'b1;
    bus.load_data    = 8'h55;
    bus.fetch_req    = 1'b1;
    bus.fetch_addr   = 3'd2;
    cyc("restart_stb_fetch");
    check("no_write_on_restart", 32'(dut.mem_q[0]), 32'hAA);

    for (int i = 0; i < 4; i++) load(8'h40 + 8'(i), "partial_load");
    do_reset("reset_mid_load");

    for (int i = 0; i < 7; i++) load(8'h50 + 8'(i), "fresh_load");
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 3'd1;
    load(8'h57, "final_write_with_fetch");
    fetch(3'd7, "fetch_last");
    fetch(3'd4, "fetch_mid");

    fetch(3'd1, "fetch_before_reset");
    do_reset("reset_cancels_valid");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
